// File: rtl/mips_mc_controller_if.sv
// Control bus between the multicycle controller and the MIPS datapath.
//   master : controller side (consumes IR fields and ALU/memory flags, drives strobes/selects)
//   slave  : datapath side (drives IR fields and flags, consumes strobes/selects)
// Signals:
//   op[5:0], funct[5:0]  IR[31:26] and IR[5:0]
//   zero, overflow       ALU flags
//   mem_ready            memory completes the current access this cycle
//   pcen, irwrite, memwrite, regwrite, exception   strobes
//   iord, regdst, memtoreg, alusrca, alusrcb[1:0], extop, pcsrc[1:0]   mux selects
//   alucont[5:0]         ALU operation (bit 5 = invert B / subtract)
interface mips_mc_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;

  logic       pcen;
  logic       irwrite;
  logic       memwrite;
  logic       iord;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       extop;
  logic [1:0] pcsrc;
  logic [5:0] alucont;
  logic       exception;

  modport master (
    input  op, funct, zero, overflow, mem_ready,
    output pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, extop, pcsrc, alucont, exception
  );

  modport slave (
    output op, funct, zero, overflow, mem_ready,
    input  pcen, irwrite, memwrite, iord, regwrite, regdst, memtoreg,
           alusrca, alusrcb, extop, pcsrc, alucont, exception
  );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute, memory and writeback and
// decodes state/op/funct/flags into the datapath strobes, mux selects and ALU code.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; returns to FETCH and masks every strobe
//   bus      mips_mc_controller_if.master (IR fields, ALU flags, mem_ready in; controls out)
// Build option:
//   OVF_TRAP_EN  when defined, ADD/SUB/ADDI with overflow go to TRAP instead of writeback.
module mips_mc_controller (
  input logic                        clk,
  input logic                        reset_n,
  mips_mc_controller_if.master       bus
);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StRtypeEx,
    StRtypeWb,
    StBrEx,
    StImmEx,
    StImmWb,
    StJEx,
    StTrap
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] AluAnd = 6'b000000;
  localparam logic [5:0] AluOr  = 6'b000001;
  localparam logic [5:0] AluAdd = 6'b000010;
  localparam logic [5:0] AluXor = 6'b000100;
  localparam logic [5:0] AluNor = 6'b000101;
  localparam logic [5:0] AluLui = 6'b000110;
  localparam logic [5:0] AluSub = 6'b100010;
  localparam logic [5:0] AluSlt = 6'b100011;

  state_e state_q, state_d;

  logic ovf_trap_en;
`ifdef OVF_TRAP_EN
  assign ovf_trap_en = 1'b1;
`else
  assign ovf_trap_en = 1'b0;
`endif

  // R-type funct decode
  logic [5:0] r_alucont;
  logic       r_valid;
  logic       r_ovf_chk;

  always_comb begin
    r_alucont = AluAnd;
    r_valid   = 1'b1;
    r_ovf_chk = 1'b0;
    unique case (bus.funct)
      6'b100000: begin r_alucont = AluAdd; r_ovf_chk = 1'b1; end
      6'b100001: r_alucont = AluAdd;
      6'b100010: begin r_alucont = AluSub; r_ovf_chk = 1'b1; end
      6'b100011: r_alucont = AluSub;
      6'b100100: r_alucont = AluAnd;
      6'b100101: r_alucont = AluOr;
      6'b100110: r_alucont = AluXor;
      6'b100111: r_alucont = AluNor;
      6'b101010: r_alucont = AluSlt;
      default:   r_valid   = 1'b0;
    endcase
  end

  // Immediate-class decode; only meaningful when op[5:3] == 3'b001
  logic [5:0] i_alucont;
  logic       i_extop;
  logic       i_valid;

  always_comb begin
    i_alucont = AluAnd;
    i_extop   = 1'b0;
    i_valid   = 1'b1;
    unique case (bus.op[2:0])
      3'b000,
      3'b001:  begin i_alucont = AluAdd; i_extop = 1'b1; end
      3'b010:  begin i_alucont = AluSlt; i_extop = 1'b1; end
      3'b011:  i_valid   = 1'b0;  // SLTIU traps
      3'b100:  i_alucont = AluAnd;
      3'b101:  i_alucont = AluOr;
      3'b110:  i_alucont = AluXor;
      3'b111:  i_alucont = AluLui;
      default: i_valid   = 1'b0;
    endcase
  end

  // Raw strobes before reset masking
  logic pcen_c, irwrite_c, memwrite_c, regwrite_c, exception_c;

  always_comb begin
    state_d      = state_q;
    pcen_c       = 1'b0;
    irwrite_c    = 1'b0;
    memwrite_c   = 1'b0;
    regwrite_c   = 1'b0;
    exception_c  = 1'b0;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.extop    = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.alucont  = AluAnd;

    unique case (state_q)
      StFetch: begin
        bus.alusrcb = 2'b01;
        bus.alucont = AluAdd;
        pcen_c      = bus.mem_ready;
        irwrite_c   = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Branch target computed speculatively into ALUOut
        bus.alusrcb = 2'b11;
        bus.alucont = AluAdd;
        if (bus.op == OpLw || bus.op == OpSw)       state_d = StMemAdr;
        else if (bus.op == OpRtype)                 state_d = StRtypeEx;
        else if (bus.op == OpBeq || bus.op == OpBne) state_d = StBrEx;
        else if (bus.op[5:3] == 3'b001)             state_d = StImmEx;
        else if (bus.op == OpJ)                     state_d = StJEx;
        else                                        state_d = StTrap;
      end
      StMemAdr: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.extop   = 1'b1;
        bus.alucont = AluAdd;
        state_d     = (bus.op == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        bus.iord = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        regwrite_c   = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        bus.iord   = 1'b1;
        memwrite_c = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StRtypeEx: begin
        bus.alusrca = 1'b1;
        bus.alucont = r_alucont;
        if (!r_valid || (ovf_trap_en && r_ovf_chk && bus.overflow)) state_d = StTrap;
        else                                                        state_d = StRtypeWb;
      end
      StRtypeWb: begin
        regwrite_c = 1'b1;
        bus.regdst = 1'b1;
        state_d    = StFetch;
      end
      StBrEx: begin
        bus.alusrca = 1'b1;
        bus.alucont = AluSub;
        bus.pcsrc   = 2'b01;
        pcen_c      = (bus.op == OpBeq) ? bus.zero : ~bus.zero;
        state_d     = StFetch;
      end
      StImmEx: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.alucont = i_alucont;
        bus.extop   = i_extop;
        if (!i_valid || (ovf_trap_en && bus.op == OpAddi && bus.overflow)) state_d = StTrap;
        else                                                               state_d = StImmWb;
      end
      StImmWb: begin
        regwrite_c = 1'b1;
        state_d    = StFetch;
      end
      StJEx: begin
        bus.pcsrc = 2'b10;
        pcen_c    = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        bus.pcsrc   = 2'b11;
        pcen_c      = 1'b1;
        exception_c = 1'b1;
        state_d     = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // Strobes are masked combinationally so nothing is written while reset is held,
  // even in the delta between reset_n falling and the state register clearing.
  assign bus.pcen      = pcen_c      & reset_n;
  assign bus.irwrite   = irwrite_c   & reset_n;
  assign bus.memwrite  = memwrite_c  & reset_n;
  assign bus.regwrite  = regwrite_c  & reset_n;
  assign bus.exception = exception_c & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StFetch;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios plus a randomized
// instruction stream checked against a per-instruction phase plan.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mips_mc_controller_if bus_if ();

  mips_mc_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int tests_run = 0;
  int tests_failed = 0;

`ifdef OVF_TRAP_EN
  localparam bit OvfTrap = 1'b1;
`else
  localparam bit OvfTrap = 1'b0;
`endif

  // Packed view of all controller outputs
  localparam int BPcen = 19, BIrw = 18, BMw = 17, BIord = 16, BRw = 15, BRd = 14, BM2r = 13;
  localparam int BAsa = 12, BExt = 9, BExc = 0;

  function automatic logic [19:0] cur();
    return {bus_if.pcen, bus_if.irwrite, bus_if.memwrite, bus_if.iord, bus_if.regwrite,
            bus_if.regdst, bus_if.memtoreg, bus_if.alusrca, bus_if.alusrcb, bus_if.extop,
            bus_if.pcsrc, bus_if.alucont, bus_if.exception};
  endfunction

  function automatic logic [19:0] ov(input logic pcen, irw, mw, iord, rw, rd, m2r, asa,
                                     input logic [1:0] asb, input logic ext,
                                     input logic [1:0] ps, input logic [5:0] ac,
                                     input logic exc);
    return {pcen, irw, mw, iord, rw, rd, m2r, asa, asb, ext, ps, ac, exc};
  endfunction

  // ---------------- trace capture for directed tests ----------------
  logic [19:0] tr [1:16];

  task automatic do_reset();
    reset_n = 1'b0;
    bus_if.mem_ready = 1'b1;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Runs n cycles from the current posedge+1 point; bit k-1 of mr_low holds mem_ready low
  task automatic run_cycles(input int n, input logic [15:0] mr_low);
    for (int k = 1; k <= n; k++) begin
      bus_if.mem_ready = ~mr_low[k-1];
      #1 tr[k] = cur();
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] mask_of(input int n, input int bitpos);
    logic [15:0] m = '0;
    for (int k = 1; k <= n; k++) m[k-1] = tr[k][bitpos];
    return m;
  endfunction

  task automatic set_instr(input logic [5:0] op, input logic [5:0] funct,
                           input logic zr, input logic ovf);
    bus_if.op = op;
    bus_if.funct = funct;
    bus_if.zero = zr;
    bus_if.overflow = ovf;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset();
    logic [19:0] v;
    set_instr(6'b101011, 6'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    bus_if.mem_ready = 1'b1;
    #2 v = cur();
    tests_run++;
    if (v[BPcen] !== 1'b0 || v[BIrw] !== 1'b0 || v[11:10] !== 2'b01 || v[6:1] !== 6'b000010) begin
      tests_failed++;
      $display("FAIL reset_hold: got %b, want pcen=0 irwrite=0 alusrcb=01 alucont=000010", v);
    end
    do_reset();
    run_cycles(3, 16'h0);  // FETCH, DECODE, MEMADR -> now in MEMWR
    bus_if.mem_ready = 1'b0;
    #1 v = cur();
    tests_run++;
    if (v[BMw] !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_memwr_pre: memwrite=%b want 1", v[BMw]);
    end
    reset_n = 1'b0;
    #1 v = cur();
    tests_run++;
    if (v[BMw] !== 1'b0 || v[BPcen] !== 1'b0 || v[BRw] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_memwr_abort: got %b want memwrite=0 pcen=0 regwrite=0", v);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus_if.mem_ready = 1'b1;
    #1 v = cur();
    tests_run++;
    if (v[BPcen] !== 1'b1 || v[BIrw] !== 1'b1 || v[11:10] !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_release_fetch: got %b want pcen=1 irwrite=1 alusrcb=01", v);
    end
    @(posedge clk);
    #1 v = cur();
    tests_run++;
    if (v[11:10] !== 2'b11 || v[BPcen] !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_then_decode: got %b want alusrcb=11 pcen=0", v);
    end
  endtask

  task automatic test_load_store();
    logic [15:0] m;
    do_reset();
    set_instr(6'b100011, 6'd0, 1'b0, 1'b0);
    run_cycles(6, 16'h0);
    m = mask_of(6, BRw) | (mask_of(6, BM2r) << 8);
    tests_run++;
    if (m !== 16'h1010 || tr[6][BIrw] !== 1'b1) begin
      tests_failed++;
      $display("FAIL lw_5cyc: regwrite|memtoreg masks=%h irw6=%b want 1010 1", m, tr[6][BIrw]);
    end
    do_reset();
    run_cycles(8, 16'b0001_1000);
    m = mask_of(8, BRw) | (mask_of(8, BIord) << 8);
    tests_run++;
    if (m !== 16'h3840) begin
      tests_failed++;
      $display("FAIL lw_wait2: regwrite|iord masks=%h want 3840", m);
    end
    do_reset();
    set_instr(6'b101011, 6'd0, 1'b0, 1'b0);
    run_cycles(7, 16'b0001_1000);
    m = mask_of(7, BMw);
    tests_run++;
    if (m !== 16'h0038 || tr[7][BIrw] !== 1'b1 || mask_of(7, BRw) !== 16'h0) begin
      tests_failed++;
      $display("FAIL sw_wait2: memwrite mask=%h irw7=%b want 0038 1", m, tr[7][BIrw]);
    end
  endtask

  task automatic test_rtype();
    do_reset();
    set_instr(6'b000000, 6'b100010, 1'b0, 1'b0);
    run_cycles(5, 16'h0);
    tests_run++;
    if (tr[3][6:1] !== 6'b100010 || tr[3][BAsa] !== 1'b1 || tr[3][11:10] !== 2'b00 ||
        tr[4][BRw] !== 1'b1 || tr[4][BRd] !== 1'b1 || mask_of(5, BRw) !== 16'h0008) begin
      tests_failed++;
      $display("FAIL rtype_sub: ex=%b wb=%b want alucont=100010 then regwrite+regdst", tr[3], tr[4]);
    end
    do_reset();
    set_instr(6'b000000, 6'b100111, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][6:1] !== 6'b000101) begin
      tests_failed++;
      $display("FAIL rtype_nor: alucont=%b want 000101", tr[3][6:1]);
    end
    do_reset();
    set_instr(6'b000000, 6'b101010, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][6:1] !== 6'b100011) begin
      tests_failed++;
      $display("FAIL rtype_slt: alucont=%b want 100011", tr[3][6:1]);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    set_instr(6'b000100, 6'd0, 1'b1, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][BPcen] !== 1'b1 || tr[3][8:7] !== 2'b01 || tr[4][BIrw] !== 1'b1) begin
      tests_failed++;
      $display("FAIL beq_taken: brex=%b next=%b want pcen=1 pcsrc=01 then fetch", tr[3], tr[4]);
    end
    do_reset();
    set_instr(6'b000101, 6'd0, 1'b1, 1'b0);
    run_cycles(3, 16'h0);
    tests_run++;
    if (tr[3][BPcen] !== 1'b0 || tr[3][8:7] !== 2'b01) begin
      tests_failed++;
      $display("FAIL bne_not_taken: brex=%b want pcen=0 pcsrc=01", tr[3]);
    end
    do_reset();
    set_instr(6'b000010, 6'd0, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][BPcen] !== 1'b1 || tr[3][8:7] !== 2'b10 || tr[4][BIrw] !== 1'b1) begin
      tests_failed++;
      $display("FAIL jump: jex=%b next=%b want pcen=1 pcsrc=10 then fetch", tr[3], tr[4]);
    end
  endtask

  task automatic test_immediate();
    do_reset();
    set_instr(6'b001111, 6'd0, 1'b0, 1'b0);
    run_cycles(5, 16'h0);
    tests_run++;
    if (tr[3][6:1] !== 6'b000110 || tr[3][BExt] !== 1'b0 || tr[4][BRw] !== 1'b1 ||
        tr[4][BRd] !== 1'b0 || tr[5][BIrw] !== 1'b1) begin
      tests_failed++;
      $display("FAIL imm_lui: ex=%b wb=%b want alucont=000110 extop=0, regwrite rt", tr[3], tr[4]);
    end
    do_reset();
    set_instr(6'b001101, 6'd0, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][BExt] !== 1'b0 || tr[3][6:1] !== 6'b000001) begin
      tests_failed++;
      $display("FAIL imm_ori: ex=%b want extop=0 alucont=000001", tr[3]);
    end
    do_reset();
    set_instr(6'b001010, 6'd0, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (tr[3][BExt] !== 1'b1 || tr[3][6:1] !== 6'b100011 || tr[3][11:10] !== 2'b10) begin
      tests_failed++;
      $display("FAIL imm_slti: ex=%b want extop=1 alucont=100011 alusrcb=10", tr[3]);
    end
  endtask

  task automatic test_trap();
    do_reset();
    set_instr(6'b111111, 6'd0, 1'b0, 1'b0);
    run_cycles(4, 16'h0);
    tests_run++;
    if (mask_of(4, BExc) !== 16'h0004 || tr[3][8:7] !== 2'b11 || tr[3][BPcen] !== 1'b1) begin
      tests_failed++;
      $display("FAIL trap_undef_op: exc mask=%h trap=%b want 0004 pcsrc=11 pcen=1",
               mask_of(4, BExc), tr[3]);
    end
    do_reset();
    set_instr(6'b000000, 6'b100000, 1'b0, 1'b1);
    run_cycles(5, 16'h0);
    tests_run++;
`ifdef OVF_TRAP_EN
    if (mask_of(5, BExc) !== 16'h0008 || mask_of(5, BRw) !== 16'h0 || tr[4][8:7] !== 2'b11) begin
      tests_failed++;
      $display("FAIL add_ovf: exc mask=%h rw mask=%h want 0008 0000",
               mask_of(5, BExc), mask_of(5, BRw));
    end
`else
    if (mask_of(5, BExc) !== 16'h0 || mask_of(5, BRw) !== 16'h0008) begin
      tests_failed++;
      $display("FAIL add_ovf_ignored: exc mask=%h rw mask=%h want 0000 0008",
               mask_of(5, BExc), mask_of(5, BRw));
    end
`endif
  endtask

  // ---------------- randomized stream vs. phase-plan model ----------------
  typedef struct {
    logic [19:0] outv;
    bit          waits;  // phase repeats until mem_ready
    bit          fetch;  // pcen/irwrite follow mem_ready
  } step_t;

  step_t plan[$];

  function automatic void push_step(input logic [19:0] v, input bit w, input bit f);
    step_t s;
    s.outv = v;
    s.waits = w;
    s.fetch = f;
    plan.push_back(s);
  endfunction

  // Builds the expected phase sequence of one instruction from the ISA rules
  function automatic void build_plan(input logic [5:0] op, input logic [5:0] funct,
                                     input logic zr, input logic ovf);
    logic [5:0] ac;
    bit ok, ovchk, ext, trap;
    logic [19:0] trap_v;
    trap_v = ov(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 6'b000000, 1);
    plan.delete();
    push_step(ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 6'b000010, 0), 1, 1);
    push_step(ov(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00, 6'b000010, 0), 0, 0);
    if (op == 6'b100011 || op == 6'b101011) begin
      push_step(ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 2'b00, 6'b000010, 0), 0, 0);
      if (op == 6'b100011) begin
        push_step(ov(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 6'b0, 0), 1, 0);
        push_step(ov(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 6'b0, 0), 0, 0);
      end else begin
        push_step(ov(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 6'b0, 0), 1, 0);
      end
    end else if (op == 6'b000000) begin
      ok = 1; ovchk = 0; ac = 6'b0;
      case (funct)
        6'd32: begin ac = 6'b000010; ovchk = 1; end
        6'd33: ac = 6'b000010;
        6'd34: begin ac = 6'b100010; ovchk = 1; end
        6'd35: ac = 6'b100010;
        6'd36: ac = 6'b000000;
        6'd37: ac = 6'b000001;
        6'd38: ac = 6'b000100;
        6'd39: ac = 6'b000101;
        6'd42: ac = 6'b100011;
        default: ok = 0;
      endcase
      push_step(ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, ac, 0), 0, 0);
      if (!ok || (OvfTrap && ovchk && ovf)) push_step(trap_v, 0, 0);
      else push_step(ov(0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 6'b0, 0), 0, 0);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      push_step(ov((op == 6'b000100) ? zr : !zr, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 2'b01,
                   6'b100010, 0), 0, 0);
    end else if (op >= 6'd8 && op <= 6'd15) begin
      trap = 0; ext = 0; ac = 6'b0;
      case (op)
        6'd8, 6'd9: begin ac = 6'b000010; ext = 1; trap = OvfTrap && op == 6'd8 && ovf; end
        6'd10: begin ac = 6'b100011; ext = 1; end
        6'd11: trap = 1;
        6'd12: ac = 6'b000000;
        6'd13: ac = 6'b000001;
        6'd14: ac = 6'b000100;
        default: ac = 6'b000110;
      endcase
      push_step(ov(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, ext, 2'b00, ac, 0), 0, 0);
      if (trap) push_step(trap_v, 0, 0);
      else push_step(ov(0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 6'b0, 0), 0, 0);
    end else if (op == 6'b000010) begin
      push_step(ov(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 6'b0, 0), 0, 0);
    end else begin
      push_step(trap_v, 0, 0);
    end
  endfunction

  task automatic test_random_stream();
    logic [5:0] ops [10];
    logic [5:0] functs [10];
    logic [5:0] op, funct;
    logic ez, eo;
    logic [19:0] v, exp;
    int idx, waits;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b000101,
            6'b001000, 6'b001000, 6'b000010, 6'b000000};
    functs = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd0};
    do_reset();
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 9))
        0: op = 6'($urandom);
        1: op = 6'(8 + $urandom_range(0, 7));
        default: ;
      endcase
      funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : functs[$urandom_range(0, 8)];
      ez = 1'($urandom);
      eo = 1'($urandom);
      build_plan(op, funct, ez, eo);
      idx = 0;
      waits = 0;
      while (idx < plan.size()) begin
        bus_if.op = op;
        bus_if.funct = funct;
        // Flags only matter in the execute phase; elsewhere they are noise
        bus_if.zero = (idx == 2) ? ez : 1'($urandom);
        bus_if.overflow = (idx == 2) ? eo : 1'($urandom);
        bus_if.mem_ready = (waits >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1 v = cur();
        exp = plan[idx].outv;
        if (plan[idx].fetch) begin
          exp[BPcen] = bus_if.mem_ready;
          exp[BIrw] = bus_if.mem_ready;
        end
        tests_run++;
        if (v !== exp) begin
          tests_failed++;
          $display("FAIL random op=%b funct=%b phase=%0d: got %b want %b", op, funct, idx, v, exp);
        end
        if (!plan[idx].waits || bus_if.mem_ready) begin
          idx++;
          waits = 0;
        end else begin
          waits++;
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    bus_if.op = '0;
    bus_if.funct = '0;
    bus_if.zero = 1'b0;
    bus_if.overflow = 1'b0;
    bus_if.mem_ready = 1'b0;
    test_reset();
    test_load_store();
    test_rtype();
    test_branch_jump();
    test_immediate();
    test_trap();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
# mips_mc_controller

Multicycle control FSM for the MIPS core: it sequences fetch, decode, execute, memory and writeback, and drives the datapath strobes, including the 6-bit `alucont` code into the ALU. It consumes the ALU's `zero` and `overflow` flags for branches and arithmetic traps. It sits between the instruction register (`op`, `funct`) and the datapath muxes and enables.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `op` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU result == 0.
- `overflow` in 1: ALU overflow flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC write enable.
- `irwrite` out 1: IR load.
- `memwrite` out 1: memory write strobe.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `regwrite` out 1: register file write.
- `regdst` out 1: destination select; 1 = rd, 0 = rt.
- `memtoreg` out 1: write-back select; 1 = MDR, 0 = ALUOut.
- `alusrca` out 1: ALU operand A; 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU operand B; 00 = B, 01 = 4, 10 = extended immediate, 11 = immediate << 2.
- `extop` out 1: immediate extension; 1 = sign-extend, 0 = zero-extend.
- `pcsrc` out 2: next-PC select; 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector 0x80.
- `alucont` out 6: bit 5 = subtract/invert B. Bits [4:0] select: 00000 AND, 00001 OR, 00010 SUM, 00011 SLT, 00100 XOR, 00101 NOR, 00110 LUI.
- `exception` out 1: one-cycle pulse when entering the trap vector.

## Operation
- 4-bit state register with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BREX, IMMEX, IMMWB, JEX, TRAP.
- Outputs are a combinational decode of state, `op`, `funct`, `zero` and `mem_ready`. Unlisted outputs are 0.
- FETCH: `alusrcb`=01, `alucont`=000010. `irwrite`=`pcen`=`mem_ready`. Holds until `mem_ready`=1, then goes to DECODE.
- DECODE: `alusrcb`=11, `alucont`=000010 (branch target into ALUOut). Next state by `op`:
  - 100011 (LW) or 101011 (SW) → MEMADR
  - 000000 → RTYPEEX
  - 000100 / 000101 → BREX
  - 001000–001111 → IMMEX
  - 000010 → JEX
  - anything else → TRAP
- MEMADR: `alusrca`=1, `alusrcb`=10, `extop`=1, ADD. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: `iord`=1; waits for `mem_ready`, then MEMWB.
- MEMWB: `regwrite`=1, `memtoreg`=1 → FETCH.
- MEMWR: `iord`=1, `memwrite`=1, held until `mem_ready`, then FETCH.
- RTYPEEX: `alusrca`=1, `alusrcb`=00. `funct` maps to `alucont`:
  - 100000/100001 → 000010
  - 100010/100011 → 100010
  - 100100 → 000000
  - 100101 → 000001
  - 100110 → 000100
  - 100111 → 000101
  - 101010 → 100011
  - Unknown `funct` → TRAP; otherwise → RTYPEWB.
- RTYPEWB: `regwrite`=1, `regdst`=1 → FETCH.
- BREX: `alusrca`=1, `alucont`=100010, `pcsrc`=01. `pcen`=`zero` for BEQ, `pcen`=~`zero` for BNE → FETCH.
- IMMEX: `alusrca`=1, `alusrcb`=10 → IMMWB. Per opcode:
  - ADDI/ADDIU: 000010, `extop`=1
  - SLTI: 100011, `extop`=1
  - SLTIU (001011): TRAP
  - ANDI: 000000, `extop`=0
  - ORI: 000001, `extop`=0
  - XORI: 000100, `extop`=0
  - LUI: 000110, `extop`=0
- IMMWB: `regwrite`=1, `regdst`=0 → FETCH.
- JEX: `pcsrc`=10, `pcen`=1 → FETCH.
- TRAP: `pcsrc`=11, `pcen`=1, `exception`=1 → FETCH.

## Timing
- Reset: state goes to FETCH immediately on `reset_n` low. All strobes (`pcen`, `irwrite`, `memwrite`, `regwrite`, `exception`) are forced to 0 while `reset_n`=0. Mux selects show FETCH values.
- Reset mid-instruction aborts it; no register write or memory write is issued after `reset_n` falls.
- Cycle counts with `mem_ready` tied high:
  - LW 5, SW 4, R-type 4, immediate 4, branch 3, J 3.
  - Trap path: trap after DECODE = 3; overflow trap = 4.
- Each `mem_ready`-low cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `memwrite` stays asserted through every wait cycle.
- `overflow` and `zero` are sampled in the EX-state cycle only.

## Configuration
- `OVF_TRAP_EN` defined:
  - In RTYPEEX with funct 100000/100010, or IMMEX with op 001000, `overflow`=1 sends the FSM to TRAP instead of the WB state.
  - No register write occurs for that instruction.
- `OVF_TRAP_EN` undefined: `overflow` is ignored; ADD/SUB/ADDI behave like ADDU/SUBU/ADDIU.

## Test plan
- Reset: `reset_n`=0 mid-MEMWR with `memwrite`=1 → `memwrite`=0 immediately. After release, FETCH with `pcen`=1 on the first cycle with `mem_ready`=1.
- LW with `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1 and `memtoreg`=1 only in cycle 5. Repeat with `mem_ready` low 2 cycles in MEMRD → 7 cycles.
- R-type SUB (funct 100010) → `alucont`=100010 in RTYPEEX; `regwrite`=1 and `regdst`=1 next cycle. NOR → 000101; SLT → 100011.
- BEQ with `zero`=1 → `pcen`=1 and `pcsrc`=01 in BREX. BNE with `zero`=1 → `pcen`=0.
- LUI → `alucont`=000110 and `extop`=0 in IMMEX; ORI → `extop`=0; SLTI → `extop`=1 and `alucont`=100011.
- ADD with `overflow`=1:
  - With `OVF_TRAP_EN`: TRAP, `exception`=1 for one cycle, `pcsrc`=11, no `regwrite`.
  - Without it: RTYPEWB. Undefined op 111111 → TRAP after DECODE.
